// File: rtl/uart_rx_os_pkg.sv
// Shared definitions for the oversampled UART receiver.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Contents: receiver state encoding, strobe-width constant shared with the
// TX block, the mid-bit sample point helper and a 3-input majority vote.
package uart_rx_os_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Oversample strobe is a single core clock wide on both RX and TX sides.
  localparam int unsigned OS_STB_CYCLES = 1;

  // Centre of a bit period in oversample ticks; samples are taken at M-1, M, M+1.
  function automatic int unsigned mid_point(input int unsigned oversample);
    return oversample / 2;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_sync_ff.sv
// Multi-stage synchronizer for an asynchronous single-bit input.
// Latency: STAGES clk_i cycles from d_i to q_o.
// Backpressure: none, free running.
//
// Ports: clk_i/rst_i (sync, active-high), d_i async input, q_o synchronized
// output. All stages reset to 1 so an idle-high line does not glitch low.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: start detect, 3-sample majority vote, LSB-first shift, stop check.
// Latency: valid_o rises one clk_i after the stop-bit decision strobe (about 9.5 bit times + sync).
// Backpressure: valid/ready; a frame that completes while a word is still pending is dropped and ovr_o pulses.
//
// Ports: clk_i, rst_i (sync, active-high), os_stb_i (1-cycle oversample strobe),
// rxd_i (async serial line, idle high), data_o/ferr_o/brk_o/valid_o with ready_i
// (received word and status), ovr_o (1-cycle overrun pulse).
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 os_stb_i,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 ferr_o,
  output logic                 brk_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 ovr_o
);

  localparam int unsigned PH_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(DATA_BITS);
  localparam int unsigned M    = mid_point(OVERSAMPLE);

  localparam logic [PH_W-1:0] PH_S0   = PH_W'(M - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(M);
  localparam logic [PH_W-1:0] PH_DEC  = PH_W'(M + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_e            state_q;
  logic [PH_W-1:0]      ph_q;
  logic [PH_W-1:0]      ph_inc;
  logic [BC_W-1:0]      bc_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 s0_q;
  logic                 s1_q;
  logic                 maj_d;
  logic                 ferr_d;
  logic                 brk_d;
  logic                 commit;
  // Cleared after a frame whose stop bit read low, so a held-low line (break)
  // must return high before another start bit is accepted.
  logic                 armed_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 ferr_q;
  logic                 brk_q;
  logic                 valid_q;
  logic                 ovr_q;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (rxd_i),
    .q_o  (rxs)
  );

  // Third sample is the live synchronized line on the decision strobe.
  assign maj_d   = maj3(s0_q, s1_q, rxs);
  assign shift_d = {maj_d, shift_q[DATA_BITS-1:1]};
  assign ferr_d  = ~maj_d;
  assign brk_d   = (shift_q == '0) & ferr_d;
  assign ph_inc  = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
  assign commit  = os_stb_i && (state_q == RX_STOP) && (ph_q == PH_DEC);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      ph_q    <= '0;
      bc_q    <= '0;
      shift_q <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      armed_q <= 1'b1;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // Output handshake; a commit below takes priority over the drop of valid.
      ovr_q <= 1'b0;
      if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      if (commit) begin
        if (!valid_q || ready_i) begin
          data_q  <= shift_q;
          ferr_q  <= ferr_d;
          brk_q   <= brk_d;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end

      if (os_stb_i) begin
        if (ph_q == PH_S0) s0_q <= rxs;
        if (ph_q == PH_S1) s1_q <= rxs;

        unique case (state_q)
          RX_IDLE: begin
            ph_q <= '0;
            if (rxs) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q <= RX_START;
            end
          end
          RX_START: begin
            ph_q <= ph_inc;
            if ((ph_q == PH_DEC) && maj_d) begin
              // False start: line was high again by mid-bit.
              state_q <= RX_IDLE;
              ph_q    <= '0;
            end else if (ph_q == PH_LAST) begin
              state_q <= RX_DATA;
              bc_q    <= '0;
            end
          end
          RX_DATA: begin
            ph_q <= ph_inc;
            if (ph_q == PH_DEC) begin
              shift_q <= shift_d;
            end
            if (ph_q == PH_LAST) begin
              if (bc_q == BC_LAST) begin
                state_q <= RX_STOP;
              end else begin
                bc_q <= bc_q + BC_W'(1);
              end
            end
          end
          RX_STOP: begin
            ph_q <= ph_inc;
            if (ph_q == PH_DEC) begin
              // Return mid-stop-bit so the next start edge is caught promptly.
              state_q <= RX_IDLE;
              ph_q    <= '0;
              if (!maj_d) armed_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign data_o  = data_q;
  assign ferr_o  = ferr_q;
  assign brk_o   = brk_q;
  assign valid_o = valid_q;
  assign ovr_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os: table vectors, randomized frames and hand sequences.
// Line model drives whole frames with fractional bit periods; the expected word is
// derived from the sent byte and stop level.
module tb_uart_rx_os;

  localparam int BIT_CLK = 48;  // 16 strobes x 3 clocks per strobe

  logic       clk_i    = 1'b0;
  logic       rst_i    = 1'b1;
  logic       os_stb_i = 1'b0;
  logic       rxd_i    = 1'b1;
  logic       ready_i  = 1'b1;
  logic [7:0] data_o;
  logic       ferr_o;
  logic       brk_o;
  logic       valid_o;
  logic       ovr_o;

  uart_rx_os #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .os_stb_i(os_stb_i),
    .rxd_i   (rxd_i),
    .data_o  (data_o),
    .ferr_o  (ferr_o),
    .brk_o   (brk_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .ovr_o   (ovr_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      os_stb_i = (cyc % 3 == 0);
    end
  end

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       b;
  } word_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         per;     // bit period in 1/100 clock
    int         glitch;  // frame bit index to glitch, -1 for none
    int         idle;    // idle bits after the frame
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    ovr_cnt  = 0;
  word_t got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: collect accepted words, count overrun pulses, check hold stability.
  logic  hold_prev = 1'b0;
  word_t prev_w;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (valid_o && ready_i) got.push_back({data_o, ferr_o, brk_o});
      if (ovr_o) ovr_cnt++;
      if (hold_prev && valid_o) check("hold_stable", 32'({data_o, ferr_o, brk_o}), 32'(prev_w));
      hold_prev = valid_o && !ready_i;
      prev_w    = {data_o, ferr_o, brk_o};
    end else begin
      hold_prev = 1'b0;
    end
  end

  function automatic word_t ref_word(input logic [7:0] d, input logic stop);
    word_t r;
    r.d = d;
    r.f = !stop;
    r.b = (d == 8'h00) && !stop;
    return r;
  endfunction

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic idle_bits(input int n);
    rxd_i = 1'b1;
    clocks(n * BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int per, input int gl);
    int         t0;
    logic [9:0] bits;
    t0   = cyc;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_i = bits[i];
      if (i == gl) begin
        wait_cyc(t0 + (i * per + per / 2) / 100);
        rxd_i = ~bits[i];
        clocks(3);
        rxd_i = bits[i];
      end
      wait_cyc(t0 + ((i + 1) * per) / 100);
    end
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    if (got.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got %0d words, expected %0d", name, got.size(), n);
    end
  endtask

  task automatic cmp_word(input string name, input word_t exp);
    word_t w;
    if (got.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no word, expected data 0x%0h", name, exp.d);
    end else begin
      w = got.pop_front();
      check({name, "_data"}, 32'(w.d), 32'(exp.d));
      check({name, "_ferr"}, 32'(w.f), 32'(exp.f));
      check({name, "_brk"},  32'(w.b), 32'(exp.b));
    end
  endtask

  vec_t vt[8];

  initial begin
    word_t exp_w;
    int    ovr0;

    vt[0] = '{8'hA5, 1'b1, 4800, -1, 0, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'h3C, 1'b1, 4800, -1, 1, 8'h3C, 1'b0, 1'b0};
    vt[2] = '{8'h81, 1'b0, 4800, -1, 2, 8'h81, 1'b1, 1'b0};
    vt[3] = '{8'h00, 1'b1, 4800,  4, 1, 8'h00, 1'b0, 1'b0};
    vt[4] = '{8'hA5, 1'b1, 4944, -1, 1, 8'hA5, 1'b0, 1'b0};
    vt[5] = '{8'hA5, 1'b1, 4656, -1, 1, 8'hA5, 1'b0, 1'b0};
    vt[6] = '{8'hFF, 1'b1, 4800, -1, 1, 8'hFF, 1'b0, 1'b0};
    vt[7] = '{8'h00, 1'b0, 4800, -1, 2, 8'h00, 1'b1, 1'b1};

    // Reset state
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data",  32'(data_o),  32'd0);
    check("rst_ferr",  32'(ferr_o),  32'd0);
    check("rst_brk",   32'(brk_o),   32'd0);
    check("rst_ovr",   32'(ovr_o),   32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    clocks(100);

    // Table vectors: back-to-back, framing error, mid-bit glitch, skew, break frame
    for (int i = 0; i < 8; i++) begin
      send_frame(vt[i].data, vt[i].stop, vt[i].per, vt[i].glitch);
      if (vt[i].idle > 0) idle_bits(vt[i].idle);
      wait_words(1, 200, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_count", i), 32'(got.size()), 32'd1);
      exp_w = '{d: vt[i].exp_data, f: vt[i].exp_ferr, b: vt[i].exp_brk};
      cmp_word($sformatf("vec%0d", i), exp_w);
      got.delete();
    end

    // Randomized frames with skew, random stop level and idle gaps
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       stop;
      int         per;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      per  = 4656 + $urandom_range(0, 288);
      send_frame(d, stop, per, -1);
      idle_bits($urandom_range(1, 3));
      wait_words(1, 200, $sformatf("rnd%0d", i));
      cmp_word($sformatf("rnd%0d", i), ref_word(d, stop));
      got.delete();
    end

    // Start-bit glitch of 4 strobes is rejected; following frame is received
    got.delete();
    rxd_i = 1'b0;
    clocks(12);
    idle_bits(2);
    check("glitch_no_word", 32'(got.size()), 32'd0);
    send_frame(8'h5A, 1'b1, 4800, -1);
    idle_bits(1);
    wait_words(1, 200, "glitch_next");
    check("glitch_next_count", 32'(got.size()), 32'd1);
    cmp_word("glitch_next", ref_word(8'h5A, 1'b1));

    // Line held low for 20 bit times: exactly one break frame
    got.delete();
    rxd_i = 1'b0;
    clocks(20 * BIT_CLK);
    idle_bits(3);
    check("break_count", 32'(got.size()), 32'd1);
    cmp_word("break", ref_word(8'h00, 1'b0));

    // Overrun: consumer stalled across two frames
    got.delete();
    ovr0    = ovr_cnt;
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 4800, -1);
    idle_bits(1);
    send_frame(8'h22, 1'b1, 4800, -1);
    idle_bits(2);
    @(negedge clk_i);
    check("ovr_valid", 32'(valid_o), 32'd1);
    check("ovr_data",  32'(data_o),  32'h11);
    check("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    check("ovr_no_xfer", 32'(got.size()), 32'd0);
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    clocks(1);
    @(negedge clk_i);
    check("ovr_valid_drop", 32'(valid_o), 32'd0);
    check("ovr_accept_count", 32'(got.size()), 32'd1);
    cmp_word("ovr_accept", ref_word(8'h11, 1'b1));
    @(posedge clk_i);
    #1;

    // Reset in the middle of DATA: partial frame lost, next frame clean
    got.delete();
    rxd_i = 1'b0;
    clocks(BIT_CLK);
    rxd_i = 1'b1;
    clocks(BIT_CLK);
    rxd_i = 1'b0;
    clocks(BIT_CLK);
    rxd_i = 1'b1;
    clocks(BIT_CLK / 2);
    rst_i = 1'b1;
    clocks(1);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_data",  32'(data_o),  32'd0);
    check("mid_rst_ferr",  32'(ferr_o),  32'd0);
    check("mid_rst_brk",   32'(brk_o),   32'd0);
    check("mid_rst_ovr",   32'(ovr_o),   32'd0);
    @(posedge clk_i);
    #1;
    idle_bits(12);
    check("mid_rst_no_word", 32'(got.size()), 32'd0);
    send_frame(8'hF0, 1'b1, 4800, -1);
    idle_bits(1);
    wait_words(1, 200, "after_rst");
    cmp_word("after_rst", ref_word(8'hF0, 1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
